// File: rtl/bitop_pkg.sv
// Shared encodings for the single-bit RMW sequencer.
// Op and state enums, datapath width, insert-value helper.
package bitop_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    OP_SET = 2'b00,
    OP_CLR = 2'b01,
    OP_TGL = 2'b10,
    OP_TST = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_MOD  = 2'b10,
    ST_WR   = 2'b11
  } state_e;

  // TST rewrites the bit with itself, so the word is unchanged
  function automatic logic ins_val(
    input op_e  op,
    input logic cur
  );
    logic s;
    s = 1'b0;
    unique case (op)
      OP_SET: s = 1'b1;
      OP_CLR: s = 1'b0;
      OP_TGL: s = ~cur;
      OP_TST: s = cur;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bit_rmw_ctrl_bitop.sv
// 16-bit single-bit insert unit.
// F equals A with bit BS replaced by S.
module Bit_OP_16bit
  import bitop_pkg::*;
(
  input  logic [DW-1:0] i_a,
  input  logic [3:0]    i_bs,
  input  logic          i_s,
  output logic [DW-1:0] o_f
);

  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_ins;

  assign w_mask = DW'(1) << i_bs;
  assign w_ins  = DW'(i_s) << i_bs;
  assign o_f    = (i_a & ~w_mask) | w_ins;

endmodule

// File: rtl/bit_rmw_ctrl.sv
// Read-modify-write sequencer for SET/CLR/TGL/TST.
// Fetches a register, inserts one bit, writes it back.
module bit_rmw_ctrl
  import bitop_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_bit,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          done,
  output logic          z_flag
);

  state_e        r_state;
  state_e        w_next;
  op_e           r_op;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_bit;
  logic [DW-1:0] r_opnd;
  logic          r_z;

  logic          w_acc;
  logic          w_wr;
  logic          w_cur;
  logic          w_s;
  logic [DW-1:0] w_f;

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_acc     = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_acc) w_next = ST_READ;
      ST_READ: w_next = ST_MOD;
      ST_MOD:  w_next = ST_WR;
      ST_WR:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_SET;
      r_addr <= '0;
      r_bit  <= '0;
    end else if (w_acc) begin
      r_op   <= op_e'(req_op);
      r_addr <= req_addr;
      r_bit  <= req_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_opnd <= '0;
    else if (r_state == ST_MOD) r_opnd <= rf_rdata;
  end

  assign w_cur = r_opnd[r_bit];
  assign w_s   = ins_val(r_op, w_cur);

  Bit_OP_16bit u_ins (
    .i_a  (r_opnd),
    .i_bs (r_bit),
    .i_s  (w_s),
    .o_f  (w_f)
  );

  always_ff @(posedge clk) begin
    if (rst)                   r_z <= 1'b0;
    else if (r_state == ST_WR) r_z <= ~w_cur;
  end

  // gating by rst keeps an aborted op from leaking a write
  assign w_wr     = (r_state == ST_WR) && !rst;
  assign rf_raddr = r_addr;
  assign rf_waddr = r_addr;
  assign rf_we    = w_wr && (r_op != OP_TST);
  assign rf_wdata = w_wr ? w_f : '0;
  assign done     = w_wr;
  assign z_flag   = r_z;

endmodule

// File: tb/tb_bit_rmw_ctrl.sv
// Self-checking bench for bit_rmw_ctrl.
// Register file and expected results modelled in the bench.
module tb_bit_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_addr;
  logic [3:0]  req_bit;
  logic [3:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        done;
  logic        z_flag;

  logic [15:0] mem   [16];
  logic [15:0] model [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bit_rmw_ctrl #(.AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_bit   (req_bit),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .done      (done),
    .z_flag    (z_flag)
  );

  always @(posedge clk) begin
    if (pl_en)      mem[pl_addr] <= pl_data;
    else if (rf_we) mem[rf_waddr] <= rf_wdata;
    rf_rdata <= mem[rf_raddr];
  end

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    model[a] = d;
  endtask

  task automatic do_op(
    input logic [1:0] op,
    input logic [3:0] a,
    input logic [3:0] b,
    input string nm
  );
    logic [15:0] mask;
    logic [15:0] nv;
    logic        ez;
    logic        ewe;
    int          w;
    mask = 16'(1) << b;
    ez   = ((model[a] & mask) == 16'h0);
    ewe  = (op != 2'b11);
    case (op)
      2'b00:   nv = model[a] | mask;
      2'b01:   nv = model[a] & ~mask;
      2'b10:   nv = model[a] ^ mask;
      default: nv = model[a];
    endcase
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    n_chk++;
    if (!req_ready) $display("FAIL %s ready_timeout ready=%b req=1", nm, req_ready);
    else n_pass++;
    req_valid = 1'b1;
    req_op = op;
    req_addr = a;
    req_bit = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_chk++;
        if (rf_raddr !== a) $display("FAIL %s raddr got=%h exp=%h", nm, rf_raddr, a);
        else n_pass++;
      end
      if (c < 3) begin
        n_chk++;
        if ({done, rf_we, req_ready} !== 3'b000)
          $display("FAIL %s busy_outs got=%b exp=000", nm, {done, rf_we, req_ready});
        else n_pass++;
      end else begin
        n_chk++;
        if ({done, rf_we, req_ready} !== {1'b1, ewe, 1'b0})
          $display("FAIL %s wr_ctl got=%b exp=%b", nm, {done, rf_we, req_ready}, {1'b1, ewe, 1'b0});
        else n_pass++;
        n_chk++;
        if (rf_waddr !== a) $display("FAIL %s waddr got=%h exp=%h", nm, rf_waddr, a);
        else n_pass++;
        n_chk++;
        if (rf_wdata !== nv) $display("FAIL %s wdata got=%h exp=%h", nm, rf_wdata, nv);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if ({z_flag, req_ready, done} !== {ez, 1'b1, 1'b0})
      $display("FAIL %s post z/ready/done got=%b exp=%b", nm, {z_flag, req_ready, done}, {ez, 2'b10});
    else n_pass++;
    model[a] = nv;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_addr = '0;
    req_bit = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready_in_rst got=%b exp=0", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({req_ready, rf_we, done, z_flag} !== 4'b1000)
      $display("FAIL reset_idle got=%b exp=1000", {req_ready, rf_we, done, z_flag});
    else n_pass++;
    n_chk++;
    if ({rf_raddr, rf_waddr, rf_wdata} !== 24'h0)
      $display("FAIL reset_buses got=%h exp=0", {rf_raddr, rf_waddr, rf_wdata});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_set();
    preload(4'd3, 16'h0000);
    do_op(2'b00, 4'd3, 4'd15, "set_r3_b15");
    n_chk++;
    if (mem[3] !== 16'h8000) $display("FAIL set_mem got=%h exp=8000", mem[3]);
    else n_pass++;
  endtask

  task automatic test_clr_tgl();
    preload(4'd5, 16'hFFFF);
    do_op(2'b01, 4'd5, 4'd0, "clr_r5_b0");
    do_op(2'b10, 4'd5, 4'd0, "tgl_r5_b0");
  endtask

  task automatic test_tst();
    preload(4'd7, 16'h0010);
    do_op(2'b11, 4'd7, 4'd4, "tst_r7_b4");
    do_op(2'b11, 4'd7, 4'd5, "tst_r7_b5");
  endtask

  task automatic test_hold_valid();
    int acc;
    int dn;
    int we;
    acc = 0;
    dn = 0;
    we = 0;
    req_valid = 1'b1;
    req_op = 2'b11;
    req_addr = 4'd7;
    req_bit = 4'd4;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready) acc++;
      if (done) dn++;
      if (rf_we) we++;
      n_chk++;
      if (req_ready !== ((c % 4) == 0))
        $display("FAIL hold_ready cyc=%0d got=%b exp=%b", c, req_ready, (c % 4) == 0);
      else n_pass++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_chk++;
    if (acc != 3 || dn != 3 || we != 0)
      $display("FAIL hold_counts acc=%0d done=%0d we=%0d exp=3/3/0", acc, dn, we);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    preload(4'd2, 16'h0000);
    req_valid = 1'b1;
    req_op = 2'b00;
    req_addr = 4'd2;
    req_bit = 4'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    if (rf_we || done) bad++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({req_ready, z_flag} !== 2'b10)
      $display("FAIL rstmid_ready_z got=%b exp=10", {req_ready, z_flag});
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      if (rf_we || done) bad++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bad != 0 || mem[2] !== 16'h0000)
      $display("FAIL rstmid_nowrite bad=%0d mem=%h exp=0/0000", bad, mem[2]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
    for (int i = 0; i < 24; i++)
      do_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), "rand");
  endtask

  initial begin
    test_reset();
    test_set();
    test_clr_tgl();
    test_tst();
    test_hold_valid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bit_rmw_ctrl.md
# bit_rmw_ctrl

Read-modify-write sequencer for single-bit instructions (SET, CLR, TGL, TST) in the 16-bit DE0 datapath. It sits directly upstream of the existing 16-bit single-bit insert unit (Bit_OP_16bit). It fetches the operand register from the register file, derives the operand A, bit select BS and insert value S, and writes the result F back. It also reports the original value of the addressed bit as a zero flag.

## Interface
- `AW`, default 4: register-file address width (16 registers).
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block idle and able to accept a request.
- `req_op`, in, 2: 00 SET, 01 CLR, 10 TGL, 11 TST.
- `req_addr`, in, AW: target register.
- `req_bit`, in, 4: bit index 0–15.
- `rf_raddr`, out, AW: register-file read address. The register file returns data one cycle later.
- `rf_rdata`, in, 16: register-file read data.
- `rf_we`, out, 1: register-file write enable.
- `rf_waddr`, out, AW: write address.
- `rf_wdata`, out, 16: write data.
- `done`, out, 1: one-cycle completion pulse.
- `z_flag`, out, 1: 1 when the addressed bit was 0 before the operation. Held until the next `done`.

## Operation
- FSM states and transitions:
  - IDLE → READ when `req_valid && req_ready`.
  - READ → MODIFY unconditionally.
  - MODIFY → WRITE unconditionally.
  - WRITE → IDLE unconditionally.
- Latching and drive:
  - On acceptance, `req_op`, `req_addr` and `req_bit` are latched into internal registers.
  - `rf_raddr` and `rf_waddr` are driven from the latched address in every state.
- MODIFY: `rf_rdata` is captured into the 16-bit operand register `opnd`.
- WRITE:
  - A = `opnd`, BS = latched bit.
  - S = 1 for SET, 0 for CLR, ~`opnd[bit]` for TGL, `opnd[bit]` for TST.
  - `rf_wdata` = F from the insert unit. Only the selected bit differs from `opnd`; the other 15 bits pass unchanged.
  - `rf_we` = 1 for SET, CLR and TGL; 0 for TST.
  - `done` = 1.
  - `z_flag` is registered as ~`opnd[bit]` for every op.
- `req_ready` = (state == IDLE) && !`rst`. Requests are ignored outside IDLE, and `req_valid` may stay high without effect.
- Reset values: state IDLE, `rf_we` 0, `done` 0, `z_flag` 0, `rf_raddr`/`rf_waddr`/`rf_wdata` 0, latched fields 0.
- Reset mid-operation: the FSM returns to IDLE on the next edge. No write and no `done` are issued for the aborted op, `z_flag` clears, and `req_ready` rises the cycle after `rst` deasserts.
- Back-to-back requests to the same register are coherent. A write committed in WRITE at cycle t+3 is visible to a read issued in READ at cycle t+5 or later.

## Timing
- Request accepted at edge t (IDLE, handshake true).
- Cycle t+1: READ, with `rf_raddr` valid.
- Cycle t+2: MODIFY, with `rf_rdata` valid and sampled at the end of the cycle.
- Cycle t+3: WRITE, with `rf_we`/`rf_wdata`/`done` asserted combinationally from state. `z_flag` updates at the end of t+3.
- Cycle t+4: IDLE, `req_ready` = 1.
- Fixed latency is 3 cycles from acceptance to `done`. Maximum throughput is one op every 4 cycles.
- No combinational path from `req_*` to `rf_*` or `done`.

## Structure
- Shared package `bitop_pkg`:
  - op encodings `OP_SET`, `OP_CLR`, `OP_TGL`, `OP_TST`;
  - state encodings `ST_IDLE`, `ST_READ`, `ST_MOD`, `ST_WR` (2-bit);
  - `DW = 16`.
- One sub-module: the existing Bit_OP_16bit insert unit, instantiated combinationally on `opnd`/latched bit/S.
- All other logic is local: FSM, latches, operand register, flag register.

## Test plan
- Reset, then idle: `req_ready` = 1, `rf_we` = 0, `done` = 0, `z_flag` = 0.
- SET: reg 3 = 0x0000, op SET, bit 15. Expect `rf_we` at t+3 with `rf_waddr` = 3, `rf_wdata` = 0x8000, `z_flag` = 1, `done` at t+3 only.
- CLR then TGL back-to-back: reg 5 = 0xFFFF.
  - CLR bit 0 → write 0xFFFE, `z_flag` = 0.
  - The next request is accepted at t+4: TGL bit 0 on reg 5 → reads 0xFFFE, writes 0xFFFF, `z_flag` = 1.
- TST: reg 7 = 0x0010, op TST, bit 4. Expect `rf_we` = 0 throughout, `done` at t+3, `z_flag` = 0. Then TST bit 5 → `z_flag` = 1.
- `req_valid` held high across a busy op: exactly one acceptance per 4 cycles, and `req_ready` = 0 in READ/MODIFY/WRITE.
- `rst` asserted during MODIFY of a SET on reg 2: no `rf_we`, no `done`, `z_flag` = 0, and `req_ready` = 1 the cycle after `rst` deasserts.
